// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the core and the iterative multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, ALU_Control, A, B,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, ALU_Control, A, B,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (shift-add) / DIV (restoring) unit with HI/LO result registers.
// Optional MDU_EARLY_OUT_EN: MULT leaves CALC once the remaining multiplier bits are all zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam int         CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Magnitude in WIDTH+1 bits so that -2^(WIDTH-1) is represented exactly.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? ((~ext) + {{WIDTH{1'b0}}, 1'b1}) : ext;
    endfunction

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 dz_q, dz_d;
    // a: MULT shifted multiplicand / DIV divisor; b: MULT multiplier / DIV dividend->quotient.
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH:0]       b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, dzo_q, dzo_d;

    logic [WIDTH:0]       a_mag_s, b_mag_s, rem_sh_s;
    logic [WIDTH+1:0]     diff_s;
    logic                 qbit_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

    // Next-state, datapath step and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_mag_s   = magnitude(bus.A);
        b_mag_s   = magnitude(bus.B);
        rem_sh_s  = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
        diff_s    = {1'b0, rem_sh_s} - {1'b0, a_q[WIDTH:0]};
        qbit_s    = ~diff_s[WIDTH+1];
        prod_s    = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        quo_s     = neg_q ? (~b_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : b_q[WIDTH-1:0];
        rem_s     = rem_neg_q ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.ALU_Control == OP_DIV)) begin
                    is_div_d  = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    acc_d     = {(2*WIDTH){1'b0}};
                    a_d       = {{(WIDTH-1){1'b0}}, b_mag_s};
                    b_d       = a_mag_s;
                    neg_d     = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    rem_neg_d = bus.A[WIDTH-1];
                    dz_d      = (bus.B == {WIDTH{1'b0}});
                    // Divide-by-zero skips the iteration and only spends one cycle before DONE.
                    state_d   = dz_d ? S_FIX : S_CALC;
                end else if (bus.start && (bus.ALU_Control == OP_MULT)) begin
                    is_div_d  = 1'b0;
                    cnt_d     = {CW{1'b0}};
                    acc_d     = {(2*WIDTH){1'b0}};
                    a_d       = {{(WIDTH-1){1'b0}}, a_mag_s};
                    b_d       = b_mag_s;
                    neg_d     = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    rem_neg_d = 1'b0;
                    dz_d      = 1'b0;
                    state_d   = S_CALC;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (is_div_q) begin
                    acc_d = qbit_s ? {{(WIDTH-1){1'b0}}, diff_s[WIDTH:0]}
                                   : {{(WIDTH-1){1'b0}}, rem_sh_s};
                    b_d   = {b_q[WIDTH-1:0], qbit_s};
                end else begin
                    acc_d = acc_q + (b_q[0] ? a_q : {(2*WIDTH){1'b0}});
                    a_d   = {a_q[2*WIDTH-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH:1]};
                end
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
`ifdef MDU_EARLY_OUT_EN
                end else if (!is_div_q && (b_q[WIDTH:1] == {WIDTH{1'b0}})) begin
                    state_d = S_FIX;
`endif
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (dz_q) begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end else if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        dzo_d  = (state_d == S_DONE) && dz_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= {(2*WIDTH){1'b0}};
            b_q       <= {(WIDTH+1){1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dzo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dzo_q     <= dzo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dzo_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a negedge monitor pops on done.
module tb_mult_div_unit;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) u_if();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(u_if));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: plain signed arithmetic on 64-bit integers, latency from the documented timing.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r, mag;
        int     hb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dz = 1'b0;
        e.acc_cyc = 0;
        if (op == OP_MULT) begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
            mag = (sb < 0) ? -sb : sb;
            hb = 0;
            for (int i = 0; i < 33; i++) if (((mag >> i) & 64'd1) != 64'd0) hb = i;
`ifdef MDU_EARLY_OUT_EN
            e.lat = hb + 3;
`else
            e.lat = 34;
`endif
        end else if (b == 32'h0) begin
            e.dz = 1'b1;
            e.hi = hi_m;
            e.lo = lo_m;
            e.lat = 2;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.lat = 34;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && u_if.done) begin
            exp_t e;
            done_seen++;
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: actual done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("HI", {32'h0, u_if.HI}, {32'h0, e.hi});
                chk("LO", {32'h0, u_if.LO}, {32'h0, e.lo});
                chk("div_by_zero", {63'h0, u_if.div_by_zero}, {63'h0, e.dz});
                chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                chk("busy_at_done", {63'h0, u_if.busy}, 64'h0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((u_if.busy || u_if.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL idle_timeout: actual busy=%b required busy=0", u_if.busy);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        e = model(op, a, b);
        u_if.start = 1'b1;
        u_if.ALU_Control = op;
        u_if.A = a;
        u_if.B = b;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        u_if.start = 1'b0;
        u_if.ALU_Control = 4'($urandom);
        u_if.A = $urandom;
        u_if.B = $urandom;
        if (!e.dz) begin
            hi_m = e.hi;
            lo_m = e.lo;
        end
        sb_q.push_back(e);
        done_exp++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL drain_timeout: actual pending=%0d required pending=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        u_if.start = 1'b0;
        u_if.ALU_Control = 4'h0;
        u_if.A = 32'h0;
        u_if.B = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'h0, u_if.busy}, 64'h0);
        chk("rst_done", {63'h0, u_if.done}, 64'h0);
        chk("rst_dz", {63'h0, u_if.div_by_zero}, 64'h0);
        chk("rst_HI", {32'h0, u_if.HI}, 64'h0);
        chk("rst_LO", {32'h0, u_if.LO}, 64'h0);

        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        @(negedge clk);
        chk("busy_T1", {63'h0, u_if.busy}, 64'h1);
        drain();
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(OP_MULT, 32'h1234_5678, 32'd1);
        issue(OP_DIV, 32'd5, 32'd0);
        drain();

        // Start during an active MULT and an invalid code in IDLE are both ignored.
        issue(OP_MULT, 32'd1000, 32'hFFFF_0001);
        repeat (4) @(negedge clk);
        u_if.start = 1'b1;
        u_if.ALU_Control = OP_DIV;
        u_if.B = 32'h0;
        @(negedge clk);
        u_if.start = 1'b0;
        drain();
        wait_idle();
        u_if.start = 1'b1;
        u_if.ALU_Control = 4'b0010;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-DIV aborts with no result and clears HI/LO.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        done_exp--;
        hi_m = 32'h0;
        lo_m = 32'h0;
        chk("abort_busy", {63'h0, u_if.busy}, 64'h0);
        chk("abort_HI", {32'h0, u_if.HI}, 64'h0);
        chk("abort_LO", {32'h0, u_if.LO}, 64'h0);
        repeat (40) @(negedge clk);

        issue(OP_MULT, 32'd9, 32'd1);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV, pick(), pick());
        end
        drain();
        repeat (5) @(negedge clk);
        chk("done_count", 64'(done_seen), 64'(done_exp));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
